// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset fetch address, instruction size and the
// prefetch entry layout.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned INSTR_W_DEFAULT  = 32;

  typedef struct packed {
    logic [31:0]                pc;
    logic [INSTR_W_DEFAULT-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; storage is registered so the head entry comes
// straight from a flop.
module ifu_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  // Flush dominates; the caller never pushes into a full FIFO.
  assign push_en = push && !flush;
  assign pop_en  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_en) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: credit-limited in-order requests to a variable-latency
// instruction memory, prefetch FIFO towards decode, and redirect with response dropping.
module ifu_prefetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INSTR_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               im_req_valid,
  input  logic               im_req_ready,
  output logic [31:0]        im_req_addr,
  input  logic               im_rsp_valid,
  input  logic [INSTR_W-1:0] im_rsp_instr,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_pc,
  output logic [INSTR_W-1:0] id_instr
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = 32 + INSTR_W;
  localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CNT_W:0]     occupancy;
  logic               credit, req_fire, rsp_accept, rsp_drop, push, pop;

  // Outstanding requests plus buffered words never exceed the FIFO size, so every
  // response is guaranteed a slot. A pop in this cycle is deliberately not credited.
  assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign credit     = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign im_req_valid = reset && credit && !redirect_valid;
  assign im_req_addr  = fetch_pc_q;
  assign req_fire   = im_req_valid && im_req_ready;

  assign rsp_accept = im_rsp_valid && (inflight_q != '0);
  assign rsp_drop   = (drop_cnt_q != '0);
  assign push       = rsp_accept && !rsp_drop && !redirect_valid;
  assign pop        = !fifo_empty && id_ready && !redirect_valid;

  assign id_valid = !fifo_empty;
  assign id_pc    = fifo_rdata[ENTRY_W-1 -: 32];
  assign id_instr = fifo_rdata[INSTR_W-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_cnt_d = drop_cnt_q;
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_accept);
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      // Everything still outstanding after this cycle belongs to the old stream.
      drop_cnt_d = inflight_q - CNT_W'(rsp_accept);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (rsp_accept && rsp_drop) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({rsp_pc_q, im_rsp_instr}),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  rsp_without_request: assert property (@(posedge clk) disable iff (!reset)
    !(im_rsp_valid && (inflight_q == '0)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch: an in-order variable-latency IM model plus an
// epoch-tagged reference of the decode stream.
module tb_ifu_prefetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_req_valid, im_req_ready;
  logic [31:0] im_req_addr;
  logic        im_rsp_valid;
  logic [31:0] im_rsp_instr;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH),
    .INSTR_W    (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req_valid   (im_req_valid),
    .im_req_ready   (im_req_ready),
    .im_req_addr    (im_req_addr),
    .im_rsp_valid   (im_rsp_valid),
    .im_rsp_instr   (im_rsp_instr),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } im_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  im_req_t     imq[$];
  entry_t      mq[$];
  int unsigned epoch, cyc, last_due, lat, pops;
  logic [31:0] exp_fetch;
  int          total, bad;

  logic        s_redirect, s_pop, s_rsp, s_fire;
  logic [31:0] s_tgt, s_addr;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    imq.delete();
    mq.delete();
    exp_fetch = RST_PC;
    last_due  = 0;
  endtask

  task automatic model_update();
    im_req_t     e;
    int unsigned old_epoch, due;
    if (!reset) begin
      clear_model();
      cyc++;
      return;
    end
    old_epoch = epoch;
    if (s_redirect) begin
      mq.delete();
      epoch++;
      exp_fetch = s_tgt & ~32'h3;
    end else if (s_pop && mq.size() != 0) begin
      void'(mq.pop_front());
      pops++;
    end
    if (s_rsp && imq.size() != 0) begin
      e = imq.pop_front();
      if (!s_redirect && e.epoch == old_epoch) mq.push_back('{e.addr, im_word(e.addr)});
    end
    if (s_fire) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      imq.push_back('{s_addr, epoch, due});
      last_due = due;
      if (!s_redirect) exp_fetch = exp_fetch + 32'd4;
    end
    cyc++;
  endtask

  task automatic drive_rsp();
    if (reset && imq.size() != 0 && imq[0].due <= cyc) begin
      im_rsp_valid = 1'b1;
      im_rsp_instr = im_word(imq[0].addr);
    end else begin
      im_rsp_valid = 1'b0;
      im_rsp_instr = $urandom;
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic cycle(input logic redir, input logic [31:0] tgt, input logic idr,
                       input logic imr);
    logic exp_req;
    redirect_valid = redir;
    redirect_pc    = tgt;
    id_ready       = idr;
    im_req_ready   = imr;
    @(negedge clk);
    check_eq("id_valid", id_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("id_pc", id_pc, mq[0].pc);
      check_eq("id_instr", id_instr, mq[0].instr);
    end
    exp_req = reset && !redir && (imq.size() + mq.size() < DEPTH);
    check_eq("req_valid", im_req_valid, exp_req);
    if (im_req_valid) check_eq("req_addr", im_req_addr, exp_fetch);
    s_redirect = redir;
    s_tgt      = tgt;
    s_pop      = id_valid && id_ready;
    s_rsp      = im_rsp_valid;
    s_fire     = im_req_valid && im_req_ready;
    s_addr     = im_req_addr;
    @(posedge clk);
    model_update();
    #1;
    drive_rsp();
  endtask

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    im_req_ready = 1'b0;
    im_rsp_valid = 1'b0;
    im_rsp_instr = '0;
    total = 0; bad = 0; epoch = 0; cyc = 0; lat = 1; pops = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_id_valid", id_valid, 1'b0);
    check_eq("rst_req_valid", im_req_valid, 1'b0);
    check_eq("rst_id_pc", id_pc, 32'h0);
    check_eq("rst_id_instr", id_instr, 32'h0);
    reset = 1'b1;

    // Streaming with 1-cycle IM, then a throughput window.
    repeat (20) cycle(1'b0, '0, 1'b1, 1'b1);
    pops = 0;
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
    check_eq("throughput", pops, 10);

    // Decode stall fills the FIFO, then drains.
    repeat (12) cycle(1'b0, '0, 1'b0, 1'b1);
    check_eq("stall_full", id_valid && !im_req_valid, 1'b1);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    // Latency 3 with requests in flight, redirect to 3100.
    lat = 3;
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_3100, 1'b1, 1'b1);
    repeat (15) cycle(1'b0, '0, 1'b1, 1'b1);

    // Redirect coinciding with response and pop, unaligned target.
    lat = 1;
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_3103, 1'b1, 1'b1);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset while stalled with a full FIFO.
    repeat (12) cycle(1'b0, '0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("async_id_valid", id_valid, 1'b0);
    check_eq("async_req_valid", im_req_valid, 1'b0);
    clear_model();
    im_rsp_valid = 1'b0;
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b1);
    reset = 1'b1;
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    // Address wrap.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0);
    end
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
